// File: rtl/fpga_fabric_pkg.sv
// Shared constants, config field layout and cell config type for the fpga_fabric slice.
package fpga_fabric_pkg;

  localparam int SIDE_W          = 80;
  localparam int N_CELLS         = 4 * SIDE_W;
  localparam int FRAME_W         = 384;
  localparam int N_FRAMES        = 267;
  localparam int CELL_CFG_W      = 64;
  localparam int CELLS_PER_FRAME = 6;
  localparam int CFG_FRAMES      = 54;

  localparam int LUT_LSB  = 0;
  localparam int SEL0_LSB = 16;
  localparam int SEL1_LSB = 25;
  localparam int SEL2_LSB = 34;
  localparam int SEL3_LSB = 43;
  localparam int REG_BIT  = 52;
  localparam int OE_BIT   = 53;

  localparam int SEL_W = 9;
  // Highest feedback select is 511, so only cells 0..191 are reachable.
  localparam int N_FB  = (1 << SEL_W) - N_CELLS;

  typedef struct packed {
    logic [9:0]       rsvd;
    logic             oe;
    logic             reg_mode;
    logic [SEL_W-1:0] sel3;
    logic [SEL_W-1:0] sel2;
    logic [SEL_W-1:0] sel1;
    logic [SEL_W-1:0] sel0;
    logic [15:0]      lut;
  } cell_cfg_t;

endpackage

// File: rtl/fpga_cell.sv
// One logic cell: four source muxes, LUT4 and optional output register.
// FPGA_FEEDBACK_EN adds the i_fb_bus port so selects 320..511 read cell FFs.
module fpga_cell
  import fpga_fabric_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_ff_en,
  input  logic [CELL_CFG_W-1:0] i_cfg,
  input  logic [N_CELLS-1:0]    i_in_bus,
`ifdef FPGA_FEEDBACK_EN
  input  logic [N_FB-1:0]       i_fb_bus,
`endif
  output logic                  o_pin,
  output logic                  o_ff_q
);

  cell_cfg_t        w_cfg;
  logic [SEL_W-1:0] w_sel [4];
  logic [3:0]       w_lut_idx;
  logic             w_lut_out;
  logic             w_unused_rsvd;
  logic             r_ff;

  assign w_cfg         = cell_cfg_t'(i_cfg);
  assign w_unused_rsvd = ^w_cfg.rsvd;
  assign w_sel[0]      = w_cfg.sel0;
  assign w_sel[1]      = w_cfg.sel1;
  assign w_sel[2]      = w_cfg.sel2;
  assign w_sel[3]      = w_cfg.sel3;

  for (genvar k = 0; k < 4; k++) begin : g_mux
    logic w_bit;
`ifdef FPGA_FEEDBACK_EN
    // For sel in 320..511, sel[7:0] = sel-256, so subtracting 64 gives sel-320.
    logic [7:0] w_fb_idx;
    assign w_fb_idx = w_sel[k][7:0] - 8'd64;
`endif
    always_comb begin
      w_bit = 1'b0;
      if (w_sel[k] < SEL_W'(N_CELLS)) begin
        w_bit = i_in_bus[w_sel[k]];
      end
`ifdef FPGA_FEEDBACK_EN
      else begin
        w_bit = i_fb_bus[w_fb_idx];
      end
`endif
    end
    assign w_lut_idx[k] = w_bit;
  end

  assign w_lut_out = w_cfg.lut[w_lut_idx];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ff <= 1'b0;
    end else if (i_ff_en) begin
      r_ff <= w_lut_out;
    end
  end

  assign o_ff_q = r_ff;
  assign o_pin  = w_cfg.oe & (w_cfg.reg_mode ? r_ff : w_lut_out);

endmodule

// File: rtl/fpga_fabric.sv
// Island-style fabric top: 54-frame config memory, 320 cells, four boundary sides.
// Define FPGA_FEEDBACK_EN to route cell FFs 0..191 back into the source muxes.
module fpga_fabric
  import fpga_fabric_pkg::*;
(
  input  logic                clock,
  input  logic                rst,
  input  logic [SIDE_W-1:0]   top_in,
  input  logic [SIDE_W-1:0]   bot_in,
  input  logic [SIDE_W-1:0]   left_in,
  input  logic [SIDE_W-1:0]   right_in,
  output logic [SIDE_W-1:0]   top_out,
  output logic [SIDE_W-1:0]   bot_out,
  output logic [SIDE_W-1:0]   left_out,
  output logic [SIDE_W-1:0]   right_out,
  input  logic                ff_en,
  input  logic [N_FRAMES-1:0] configs_en,
  input  logic [FRAME_W-1:0]  configs_in
);

  // The last stored frame only feeds two cells; the rest of it is dead.
  localparam int LAST_USED_W = (N_CELLS - (CFG_FRAMES - 1) * CELLS_PER_FRAME) * CELL_CFG_W;

  logic [FRAME_W-1:0] r_frames [CFG_FRAMES];
  logic [N_CELLS-1:0] w_in_bus;
  logic [N_CELLS-1:0] w_pin;
  logic [N_CELLS-1:0] w_ff_q;
  logic               w_unused_en;
  logic               w_unused_tail;
  logic               w_unused_ff;

  assign w_in_bus      = {right_in, left_in, bot_in, top_in};
  assign w_unused_en   = ^configs_en[N_FRAMES-1:CFG_FRAMES];
  assign w_unused_tail = ^r_frames[CFG_FRAMES-1][FRAME_W-1:LAST_USED_W];
  assign w_unused_ff   = ^w_ff_q;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int f = 0; f < CFG_FRAMES; f++) begin
        r_frames[f] <= '0;
      end
    end else begin
      for (int f = 0; f < CFG_FRAMES; f++) begin
        if (configs_en[f]) begin
          r_frames[f] <= configs_in;
        end
      end
    end
  end

  for (genvar c = 0; c < N_CELLS; c++) begin : g_cell
    fpga_cell u_cell (
      .i_clk    (clock),
      .i_rst_n  (rst),
      .i_ff_en  (ff_en),
      .i_cfg    (r_frames[c / CELLS_PER_FRAME][CELL_CFG_W * (c % CELLS_PER_FRAME) +: CELL_CFG_W]),
      .i_in_bus (w_in_bus),
`ifdef FPGA_FEEDBACK_EN
      .i_fb_bus (w_ff_q[N_FB-1:0]),
`endif
      .o_pin    (w_pin[c]),
      .o_ff_q   (w_ff_q[c])
    );
  end

  assign top_out   = w_pin[SIDE_W-1:0];
  assign bot_out   = w_pin[2*SIDE_W-1:SIDE_W];
  assign left_out  = w_pin[3*SIDE_W-1:2*SIDE_W];
  assign right_out = w_pin[4*SIDE_W-1:3*SIDE_W];

endmodule

// File: tb/tb_fpga_fabric.sv
// Directed bench for fpga_fabric: reset, routing, frame addressing, registers, feedback, full bitstream.
module tb_fpga_fabric;

  logic         clock;
  logic         rst;
  logic [79:0]  top_in, bot_in, left_in, right_in;
  logic [79:0]  top_out, bot_out, left_out, right_out;
  logic         ff_en;
  logic [266:0] configs_en;
  logic [383:0] configs_in;
  logic [319:0] w_out;

  int n_tests = 0;
  int n_fail  = 0;

  logic [383:0] mem [54];

  fpga_fabric dut (
    .clock      (clock),
    .rst        (rst),
    .top_in     (top_in),
    .bot_in     (bot_in),
    .left_in    (left_in),
    .right_in   (right_in),
    .top_out    (top_out),
    .bot_out    (bot_out),
    .left_out   (left_out),
    .right_out  (right_out),
    .ff_en      (ff_en),
    .configs_en (configs_en),
    .configs_in (configs_in)
  );

  assign w_out = {right_out, left_out, bot_out, top_out};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mkcfg(input logic [15:0] lut, input logic [8:0] s0, input logic [8:0] s1,
                                        input logic [8:0] s2, input logic [8:0] s3, input logic rg, input logic oe);
    return {10'b0, oe, rg, s3, s2, s1, s0, lut};
  endfunction

  function automatic logic [319:0] rand320();
    logic [319:0] v;
    for (int i = 0; i < 10; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [383:0] rand384();
    logic [383:0] v;
    for (int i = 0; i < 12; i++) v[32*i +: 32] = $urandom;
    return v;
  endfunction

  // Reference: combinational cells only; all FFs are known to be 0 when it is used.
  function automatic logic [319:0] model(input logic [319:0] inb);
    logic [319:0] r;
    logic [63:0]  cfg;
    logic [8:0]   s;
    logic [3:0]   idx;
    r = '0;
    for (int c = 0; c < 320; c++) begin
      cfg = 64'(mem[c/6] >> (64 * (c % 6)));
      for (int k = 0; k < 4; k++) begin
        s = cfg[16 + 9*k +: 9];
        idx[k] = (s < 9'd320) ? inb[s] : 1'b0;
      end
      r[c] = cfg[53] & ~cfg[52] & cfg[idx];
    end
    return r;
  endfunction

  task automatic set_in(input logic [319:0] v);
    top_in   = v[79:0];
    bot_in   = v[159:80];
    left_in  = v[239:160];
    right_in = v[319:240];
  endtask

  task automatic write_frame(input logic [266:0] en, input logic [383:0] data);
    @(negedge clock);
    configs_en = en;
    configs_in = data;
    @(posedge clock);
    #1;
    configs_en = '0;
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    rst = 1'b0;
    @(negedge clock);
    rst = 1'b1;
  endtask

  initial begin
    logic [319:0] v;
    logic [319:0] e;
    logic [319:0] v0;
    logic [383:0] d;

    rst        = 1'b0;
    ff_en      = 1'b0;
    configs_en = '0;
    configs_in = '0;
    set_in(rand320());

    // Reset with random inputs and random config traffic
    #1;
    check("reset_outputs_zero", w_out, '0);
    configs_en = '1;
    configs_in = '1;
    repeat (2) @(posedge clock);
    #1;
    check("reset_ignores_writes", w_out, '0);
    configs_en = '0;
    @(negedge clock);
    rst = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    check("post_reset_no_config", w_out, '0);

    // Passthrough of right_in[0] (src 240) into cell 0
    set_in('0);
    write_frame(267'b1, {320'b0, mkcfg(16'hAAAA, 9'd240, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1)});
    #1;
    check("pass_r0_low", w_out, '0);
    right_in[0] = 1'b1;
    #1;
    check("pass_r0_high", w_out, 320'b1);
    right_in[0] = 1'b0;
    #1;
    check("pass_r0_back_low", w_out, '0);

    // Reset between writes wipes the loaded frame
    right_in[0] = 1'b1;
    pulse_reset();
    #1;
    check("reset_discards_frames", w_out, '0);
    set_in('0);

    // Frame 53: cells 318,319 (slots 0,1) pass right_in[3] = src 243; slots 4,5 have no cells
    d = '0;
    d[63:0]    = mkcfg(16'hAAAA, 9'd243, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1);
    d[127:64]  = mkcfg(16'hAAAA, 9'd243, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1);
    d[319:256] = mkcfg(16'hAAAA, 9'd243, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1);
    d[383:320] = mkcfg(16'hAAAA, 9'd243, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1);
    write_frame(267'b1 << 53, d);
    right_in[3] = 1'b1;
    #1;
    e = '0;
    e[318] = 1'b1;
    e[319] = 1'b1;
    check("frame53_high", w_out, e);
    right_in[3] = 1'b0;
    #1;
    check("frame53_low", w_out, '0);

    // Two frame enables at once load the same data: cells 6 and 12 pass top_in[3]
    write_frame(267'b110, {320'b0, mkcfg(16'hAAAA, 9'd3, 9'd0, 9'd0, 9'd0, 1'b0, 1'b1)});
    top_in[3] = 1'b1;
    #1;
    e = '0;
    e[6]  = 1'b1;
    e[12] = 1'b1;
    check("multi_frame_write", w_out, e);
    pulse_reset();
    set_in('0);

    // Cell 5: registered AND of top_in[0] and top_in[1]
    write_frame(267'b1, {mkcfg(16'h8888, 9'd0, 9'd1, 9'd0, 9'd0, 1'b1, 1'b1), 320'b0});
    top_in[1:0] = 2'b11;
    @(posedge clock);
    #1;
    check("and_reg_ff_en_off", w_out, '0);
    ff_en = 1'b1;
    #1;
    check("and_reg_before_edge", w_out, '0);
    @(posedge clock);
    #1;
    check("and_reg_captured", w_out, 320'b1 << 5);
    ff_en = 1'b0;
    top_in[1:0] = 2'b00;
    @(posedge clock);
    #1;
    check("and_reg_hold", w_out, 320'b1 << 5);
    ff_en = 1'b1;
    top_in[1:0] = 2'b01;
    @(posedge clock);
    #1;
    check("and_reg_clear", w_out, '0);

    // Same-edge config write: FF captures with the old LUT (AND -> 1), then new LUT 0 takes over
    top_in[1:0] = 2'b11;
    write_frame(267'b1, {mkcfg(16'h0000, 9'd0, 9'd1, 9'd0, 9'd0, 1'b1, 1'b1), 320'b0});
    check("same_edge_old_config", w_out, 320'b1 << 5);
    @(posedge clock);
    #1;
    check("same_edge_new_config", w_out, '0);
    ff_en = 1'b0;
    pulse_reset();
    set_in('0);

    // Cell 0 inverts its own FF (sel 320)
    write_frame(267'b1, {320'b0, mkcfg(16'h5555, 9'd320, 9'd0, 9'd0, 9'd0, 1'b1, 1'b1)});
    check("fb_initial", w_out, '0);
    ff_en = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clock);
      #1;
`ifdef FPGA_FEEDBACK_EN
      e = 320'((k % 2) == 1);
`else
      e = 320'b1;
`endif
      check($sformatf("feedback_edge%0d", k), w_out, e);
    end
    ff_en = 1'b0;
    pulse_reset();

    // Full bitstream, one-hot enable walking across all 267 frames
    for (int f = 0; f < 54; f++) mem[f] = '0;
    v0 = rand320();
    set_in(v0);
    for (int f = 0; f < 267; f++) begin
      d = rand384();
      if (f < 54) mem[f] = d;
      write_frame(267'b1 << f, d);
      if (f == 53) check("bitstream_cfg_frames", w_out, model(v0));
    end
    #1;
    check("bitstream_extra_frames_no_effect", w_out, model(v0));
    for (int t = 0; t < 4; t++) begin
      v = rand320();
      set_in(v);
      #1;
      check($sformatf("bitstream_vec%0d", t), w_out, model(v));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
